// File: rtl/uart_pkg.sv
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared types and default rates for the UART transmitter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  // Frame sequencing states of the transmitter.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int DEFAULT_CLK_FREQ = 100_000_000;
  localparam int DEFAULT_BAUD     = 9600;

endpackage

`default_nettype wire

// File: rtl/uart_baud_counter.sv
// ============================================================================
// Module   : uart_baud_counter
// Brief    : Counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
//            Held at zero while clear is high so the first bit after leaving
//            idle gets its full length.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_end
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] c_last = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;

  // Free-running bit timer that wraps on every bit boundary.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_cnt <= '0;
    end else if (r_cnt == c_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign bit_end = !clear && (r_cnt == c_last);

endmodule

`default_nettype wire

// File: rtl/uart_tx.sv
// ============================================================================
// Module   : uart_tx
// Brief    : 8N1 UART transmitter. Accepts one byte on an axiiv strobe in
//            idle, shifts it out LSB first and pulses done once the stop bit
//            has finished. Line and done are driven straight from flops.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = DEFAULT_CLK_FREQ,
  parameter int BAUD         = DEFAULT_BAUD,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       axiiv,
  input  logic [7:0] axiid,
  output logic       axiod,
  output logic       done
);

  tx_state_t  r_state;
  tx_state_t  w_next;
  logic [7:0] r_shreg;
  logic [2:0] r_idx;
  logic       r_axiod;
  logic       r_stop_end;
  logic       r_done;
  logic       w_line;
  logic       w_clear;
  logic       w_bit_end;

  assign w_clear = (r_state == IDLE);

  uart_baud_counter #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .clear   (w_clear),
    .bit_end (w_bit_end)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state selection and the line level owed to the current state.
  always_comb begin
    w_next = r_state;
    w_line = 1'b1;
    case (r_state)
      IDLE: begin
        if (axiiv) begin
          w_next = START;
        end
      end
      START: begin
        w_line = 1'b0;
        if (w_bit_end) begin
          w_next = DATA;
        end
      end
      DATA: begin
        w_line = r_shreg[r_idx];
        if (w_bit_end && (r_idx == 3'd7)) begin
          w_next = STOP;
        end
      end
      STOP: begin
        if (w_bit_end) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Byte capture on the accepting edge and bit index stepping through DATA.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shreg <= 8'h00;
      r_idx   <= 3'd0;
    end else begin
      if ((r_state == IDLE) && axiiv) begin
        r_shreg <= axiid;
      end
      if (r_state == START) begin
        r_idx <= 3'd0;
      end else if ((r_state == DATA) && w_bit_end) begin
        r_idx <= r_idx + 3'd1;
      end
    end
  end

  // Output flops; done trails the stop-bit end by one cycle to line up with
  // the registered line, so it marks the moment the stop bit actually ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_axiod    <= 1'b1;
      r_stop_end <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_axiod    <= w_line;
      r_stop_end <= (r_state == STOP) && w_bit_end;
      r_done     <= r_stop_end;
    end
  end

  assign axiod = r_axiod;
  assign done  = r_done;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
// ============================================================================
// Module   : tb_uart_tx
// Brief    : Scoreboard bench for uart_tx. Accepted bytes are queued with
//            their accept cycle; a line monitor decodes each frame and checks
//            bit values, bit widths, start latency and done timing.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx;

  localparam int CPB = 16;

  typedef struct {
    logic [7:0] data;
    int         acc;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       axiiv;
  logic [7:0] axiid;
  logic       axiod;
  logic       done;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t q[$];

  int         exp_done = -1;
  int         spurious = 0;
  int         dones = 0;
  bit         m_in = 1'b0;
  int         m_start = 0;
  logic [9:0] m_exp = '0;
  logic [9:0] m_obs = '0;
  logic [9:0] m_bad = '0;

  uart_tx #(
    .CLK_FREQ     (100_000_000),
    .BAUD         (9600),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .axiiv (axiiv),
    .axiid (axiid),
    .axiod (axiod),
    .done  (done)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Posedge counter; at a negedge it equals the index of the edge just taken.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Drives a strobe from a negedge; the byte is queued with its accept edge.
  task automatic send(input logic [7:0] d, input int hold);
    exp_t e;
    axiiv = 1'b1;
    axiid = d;
    @(negedge clk);
    e.data = d;
    e.acc  = cyc;
    q.push_back(e);
    for (int i = 1; i < hold; i++) @(negedge clk);
    axiiv = 1'b0;
    axiid = ~d;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while ((done !== 1'b1) && (n < 12 * CPB)) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(done), 32'd1);
  endtask

  // Line monitor: decodes frames and pops the scoreboard.
  initial begin
    exp_t e;
    int   off;
    int   b;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        m_in     = 1'b0;
        exp_done = -1;
      end else begin
        if (exp_done == cyc) begin
          check_eq("done_pulse", 32'(done), 32'd1);
          if (done === 1'b1) dones++;
          exp_done = -1;
        end else if (done !== 1'b0) begin
          spurious++;
        end
        if (!m_in && (axiod === 1'b0)) begin
          m_in    = 1'b1;
          m_start = cyc;
          m_bad   = '0;
          m_obs   = '0;
          check_eq("frame_expected", 32'(q.size() != 0), 32'd1);
          if (q.size() != 0) begin
            e     = q.pop_front();
            m_exp = {1'b1, e.data, 1'b0};
            check_eq("start_latency", 32'(cyc), 32'(e.acc + 1));
          end else begin
            m_exp = 10'h3FF;
          end
        end
        if (m_in) begin
          off = cyc - m_start;
          b   = off / CPB;
          if (axiod !== m_exp[b]) m_bad[b] = 1'b1;
          if ((off % CPB) == (CPB / 2)) m_obs[b] = axiod;
          if (off == 10 * CPB - 1) begin
            check_eq("frame_bits", 32'(m_obs), 32'(m_exp));
            check_eq("bit_timing", 32'(m_bad), 32'd0);
            exp_done = m_start + 10 * CPB;
            m_in     = 1'b0;
          end
        end
      end
    end
  end

  // Stimulus sequence.
  initial begin
    rst   = 1'b1;
    axiiv = 1'b0;
    axiid = 8'h00;
    repeat (3) @(negedge clk);
    check_eq("reset_line", 32'(axiod), 32'd1);
    check_eq("reset_done", 32'(done), 32'd0);
    rst = 1'b0;

    repeat (2100) @(negedge clk);
    check_eq("idle_line", 32'(axiod), 32'd1);
    check_eq("idle_no_done", 32'(spurious), 32'd0);

    // 0xAA with a two-cycle strobe.
    send(8'hAA, 2);
    wait_done("done_aa");

    // 0xCC after the first frame.
    repeat (5) @(negedge clk);
    send(8'hCC, 1);
    wait_done("done_cc");

    // 0x55 strobe in the middle of an 0xAA frame must be dropped.
    repeat (5) @(negedge clk);
    send(8'hAA, 1);
    repeat (3 * CPB) @(negedge clk);
    axiiv = 1'b1;
    axiid = 8'h55;
    @(negedge clk);
    axiiv = 1'b0;
    wait_done("done_aa_mid");

    // Back-to-back: new strobe in the done cycle.
    repeat (5) @(negedge clk);
    send(8'h33, 1);
    wait_done("done_33");
    send(8'h0F, 1);
    wait_done("done_0f");

    // Reset during DATA abandons the frame.
    repeat (5) @(negedge clk);
    send(8'hA5, 1);
    repeat (4 * CPB) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_line", 32'(axiod), 32'd1);
    check_eq("midrst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12 * CPB) @(negedge clk);
    check_eq("midrst_idle", 32'(axiod), 32'd1);
    send(8'h3C, 1);
    wait_done("done_3c");

    repeat (2 * CPB) @(negedge clk);
    check_eq("spurious_done", 32'(spurious), 32'd0);
    check_eq("done_count", 32'(dones), 32'd6);
    check_eq("queue_empty", 32'(q.size()), 32'd0);
    check_eq("monitor_idle", 32'(m_in), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
